// File: rtl/layer_lut_sequencer_if.sv
// Frame in/out handshakes and config port of the layer LUT sequencer.
// master drives frames and config; slave is the sequencer.
interface layer_lut_sequencer_if #(
    parameter int N_IN      = 32,
    parameter int N_NEURONS = 16,
    parameter int FANIN     = 6
);
    localparam int AW  = $clog2(N_NEURONS);
    localparam int TTW = 2 ** FANIN;

    logic [N_IN-1:0]      in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [N_NEURONS-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 cfg_we;
    logic                 cfg_sel;
    logic [AW-1:0]        cfg_addr;
    logic [TTW-1:0]       cfg_data;
    logic                 cfg_ready;

    modport master (
        output in_data, in_valid,
        input  in_ready,
        input  out_data, out_valid,
        output out_ready,
        output cfg_we, cfg_sel, cfg_addr, cfg_data,
        input  cfg_ready
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready,
        output out_data, out_valid,
        input  out_ready,
        input  cfg_we, cfg_sel, cfg_addr, cfg_data,
        output cfg_ready
    );
endinterface

// File: rtl/layer_lut_sequencer.sv
// Shared 6-input LUT evaluating one neuron of a layer per cycle.
// Define LUT_SEQ_FRAME_CNT_EN to build the saturating frame counter.
module layer_lut_sequencer #(
    parameter int N_IN      = 32,
    parameter int N_NEURONS = 16,
    parameter int FANIN     = 6,
    parameter int IDXW      = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    layer_lut_sequencer_if.slave bus,
    output logic [31:0]          frame_cnt
);
    localparam int TTW = 2 ** FANIN;
    localparam int FW  = FANIN * IDXW;
    localparam int KW  = $clog2(N_NEURONS);

    typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

    state_t                        state_q, state_d;
    logic [N_NEURONS-1:0][TTW-1:0] tt_q, tt_d;
    logic [N_NEURONS-1:0][FW-1:0]  fidx_q, fidx_d;
    logic [N_IN-1:0]               in_reg_q, in_reg_d;
    logic [N_NEURONS-1:0]          out_data_q, out_data_d;
    logic [KW-1:0]                 k_q, k_d;
    logic [FANIN-1:0]              lut_addr;
    logic [IDXW-1:0]               idx;
    logic                          last_k;

    assign last_k       = (k_q == KW'(N_NEURONS - 1));
    assign bus.out_data = out_data_q;

    // State, tables, latched frame and result register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tt_q       <= '0;
            fidx_q     <= '0;
            in_reg_q   <= '0;
            out_data_q <= '0;
            k_q        <= '0;
        end else begin
            state_q    <= state_d;
            tt_q       <= tt_d;
            fidx_q     <= fidx_d;
            in_reg_q   <= in_reg_d;
            out_data_q <= out_data_d;
            k_q        <= k_d;
        end
    end

    // Next state: accept, sweep all neurons, hold until taken
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.in_valid) state_d = EVAL;
            EVAL:    if (last_k) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.cfg_ready = 1'b0;
        bus.out_valid = 1'b0;
        unique case (1'b1)
            (state_q == IDLE): begin
                bus.in_ready  = 1'b1;
                bus.cfg_ready = 1'b1;
            end
            (state_q == DONE): bus.out_valid = 1'b1;
            default: ;
        endcase
    end

    // Gather the current neuron's fan-in bits into the LUT address
    always_comb begin
        lut_addr = '0;
        idx      = '0;
        for (int i = 0; i < FANIN; i++) begin
            idx = fidx_q[k_q][i*IDXW +: IDXW];
            lut_addr[i] = (int'(idx) < N_IN) ? in_reg_q[idx] : 1'b0;
        end
    end

    // Config writes and frame latch in IDLE; one LUT lookup per EVAL cycle
    always_comb begin
        tt_d       = tt_q;
        fidx_d     = fidx_q;
        in_reg_d   = in_reg_q;
        out_data_d = out_data_q;
        k_d        = k_q;
        if (state_q == IDLE) begin
            if (bus.cfg_we && int'(bus.cfg_addr) < N_NEURONS) begin
                if (bus.cfg_sel) fidx_d[bus.cfg_addr] = bus.cfg_data[FW-1:0];
                else             tt_d[bus.cfg_addr]   = bus.cfg_data;
            end
            if (bus.in_valid) begin
                in_reg_d = bus.in_data;
                k_d      = '0;
            end
        end
        if (state_q == EVAL) begin
            out_data_d[k_q] = tt_q[k_q][lut_addr];
            k_d = last_k ? '0 : k_q + 1'b1;
        end
    end

`ifdef LUT_SEQ_FRAME_CNT_EN
    logic [31:0] frame_cnt_q, frame_cnt_d;

    // Count delivered frames, sticking at all-ones
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (bus.out_valid && bus.out_ready && frame_cnt_q != 32'hFFFF_FFFF)
            frame_cnt_d = frame_cnt_q + 32'd1;
    end

    // Frame counter register
    always_ff @(posedge clk) begin
        if (!rst_n) frame_cnt_q <= '0;
        else        frame_cnt_q <= frame_cnt_d;
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_layer_lut_sequencer.sv
// Scoreboard bench for layer_lut_sequencer.
// Expected frames are modelled at accept and compared at output.
module tb_layer_lut_sequencer;
    localparam int N_IN  = 32;
    localparam int NN    = 16;
    localparam int FANIN = 6;
    localparam int IDXW  = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] frame_cnt;

    always #5 clk = ~clk;

    layer_lut_sequencer_if #(.N_IN(N_IN), .N_NEURONS(NN), .FANIN(FANIN)) bus ();

    layer_lut_sequencer #(
        .N_IN(N_IN), .N_NEURONS(NN), .FANIN(FANIN), .IDXW(IDXW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .frame_cnt(frame_cnt)
    );

    logic [63:0] tt_m [NN];
    logic [29:0] fidx_m [NN];
    logic [15:0] sb [$];
    int cyc = 0;
    int acc_cyc = 0;
    int n_chk = 0;
    int n_err = 0;
    int frames_done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [31:0] d);
        logic [15:0]     r;
        logic [5:0]      a;
        logic [IDXW-1:0] ix;
        r = '0;
        for (int k = 0; k < NN; k++) begin
            a = '0;
            for (int i = 0; i < FANIN; i++) begin
                ix = fidx_m[k][i*IDXW +: IDXW];
                a[i] = (int'(ix) < N_IN) ? d[ix] : 1'b0;
            end
            r[k] = tt_m[k][a];
        end
        return r;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < NN; k++) begin
            tt_m[k] = '0;
            fidx_m[k] = '0;
        end
    endtask

    task automatic model_write(input bit sel, input int addr,
                               input logic [63:0] d);
        if (sel) fidx_m[addr] = d[29:0];
        else     tt_m[addr] = d;
    endtask

    task automatic cfg_write(input bit sel, input int addr,
                             input logic [63:0] d, input bit taken);
        bus.cfg_we = 1'b1;
        bus.cfg_sel = sel;
        bus.cfg_addr = 4'(addr);
        bus.cfg_data = d;
        chk("cfg_ready", bus.cfg_ready, taken);
        @(posedge clk);
        if (taken) model_write(sel, addr, d);
        #1 bus.cfg_we = 1'b0;
    endtask

    task automatic start_frame(input logic [31:0] d, input bit do_cfg = 0,
                               input bit sel = 0, input int addr = 0,
                               input logic [63:0] cd = '0);
        int t = 0;
        while (bus.in_ready !== 1'b1 && t < 64) begin
            @(posedge clk);
            #1 t++;
        end
        chk("in_ready_wait", bus.in_ready, 1);
        bus.in_data = d;
        bus.in_valid = 1'b1;
        if (do_cfg) begin
            bus.cfg_we = 1'b1;
            bus.cfg_sel = sel;
            bus.cfg_addr = 4'(addr);
            bus.cfg_data = cd;
        end
        @(posedge clk);
        if (do_cfg) model_write(sel, addr, cd);
        sb.push_back(model(d));
        #1;
        bus.in_valid = 1'b0;
        bus.cfg_we = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic wait_out();
        int t = 0;
        while (bus.out_valid !== 1'b1 && t < 100) begin
            @(posedge clk);
            #1 t++;
        end
        chk("latency", 64'(cyc - acc_cyc), 64'd16);
    endtask

    task automatic take_out();
        logic [15:0] e;
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
            return;
        end
        e = sb.pop_front();
        chk("out_data", bus.out_data, e);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        frames_done++;
        chk("out_valid_drop", bus.out_valid, 0);
        chk("back_idle", bus.in_ready, 1);
    endtask

    task automatic check_frame_cnt();
        logic [31:0] exp;
`ifdef LUT_SEQ_FRAME_CNT_EN
        exp = 32'(frames_done);
`else
        exp = 32'd0;
`endif
        chk("frame_cnt", frame_cnt, exp);
    endtask

    initial begin
        bus.in_data = '0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.cfg_we = 1'b0;
        bus.cfg_sel = 1'b0;
        bus.cfg_addr = '0;
        bus.cfg_data = '0;
        model_clear();

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_cfg_ready", bus.cfg_ready, 1);
        chk("rst_frame_cnt", frame_cnt, 0);

        // all-ones frame on empty tables
        start_frame(32'hFFFF_FFFF);
        wait_out();
        chk("t1_const", bus.out_data, 16'h0000);
        take_out();

        // single-neuron table, fan-in 0 from bit 7
        cfg_write(0, 3, 64'h2, 1);
        cfg_write(1, 3, 64'd7, 1);
        start_frame(32'h0000_0080);
        wait_out();
        chk("t2_const", bus.out_data, 16'h0008);
        take_out();

        // stall in DONE with in_valid pushing
        start_frame(32'h0000_0080);
        wait_out();
        for (int c = 0; c < 10; c++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 32'hFFFF_FFFF;
            @(posedge clk);
            #1;
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_data", bus.out_data, 16'h0008);
            chk("hold_in_ready", bus.in_ready, 0);
        end
        bus.in_valid = 1'b0;
        take_out();

        // config write during EVAL must be dropped
        start_frame(32'h0000_0001);
        cfg_write(0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        wait_out();
        take_out();
        start_frame(32'h0000_0001);
        wait_out();
        take_out();

        // write landing on the same edge as accept
        start_frame(32'h0000_0001, 1, 0, 6, 64'h8000_0000_0000_0000);
        wait_out();
        take_out();

        // random tables and frames
        for (int r = 0; r < 4; r++) begin
            cfg_write(0, r * 3 + 1, {$urandom, $urandom}, 1);
            cfg_write(1, r * 3 + 1, 64'({$urandom} & 32'h3FFF_FFFF), 1);
            cfg_write(0, 15 - r, {$urandom, $urandom}, 1);
            start_frame($urandom);
            wait_out();
            take_out();
        end
        check_frame_cnt();

        // reset in mid-EVAL
        cfg_write(0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        cfg_write(0, 5, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        start_frame(32'hFFFF_FFFF);
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        sb.delete();
        model_clear();
        frames_done = 0;
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_in_ready", bus.in_ready, 1);
        chk("mid_rst_data", bus.out_data, 0);
        chk("mid_rst_frame_cnt", frame_cnt, 0);
        start_frame(32'hFFFF_FFFF);
        wait_out();
        chk("t5_const", bus.out_data, 16'h0000);
        take_out();

        // three frames since reset
        start_frame(32'h1234_5678);
        wait_out();
        take_out();
        start_frame(32'h8765_4321);
        wait_out();
        take_out();
        check_frame_cnt();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
